lsd_output_buffer_db: RTL and testbench

//  Double-buffered (ping-pong) store for line segments emitted by simple_lsd, read by the PS.

---
 rtl/lsd_output_buffer_db_if.sv | 48 ++++
 rtl/lsd_output_buffer_db.sv | 193 +++++++++++++++++++
 tb/tb_lsd_output_buffer_db.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsd_output_buffer_db_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsd_output_buffer_db_if
//  Description : Bus bundle between simple_lsd / PS and lsd_output_buffer_db.
//                slave  : buffer side (segment + read request in, status out)
//                master : producer/consumer side (the mirror image)
//                Segment write : in_flag, in_valid, in_start_v/h, in_end_v/h
//                PS read       : in_rd_en, in_rd_addr, out_data_valid, out_data
//                PS status     : in_release, out_ready, out_line_num,
//                                out_overflow, out_drop_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsd_output_buffer_db_if #(
  parameter int V_BITW    = 10,
  parameter int H_BITW    = 10,
  parameter int ADDR_BITW = 12
);
  logic                          in_flag;
  logic                          in_valid;
  logic [V_BITW-1:0]             in_start_v;
  logic [H_BITW-1:0]             in_start_h;
  logic [V_BITW-1:0]             in_end_v;
  logic [H_BITW-1:0]             in_end_h;
  logic                          in_rd_en;
  logic [ADDR_BITW-1:0]          in_rd_addr;
  logic                          in_release;
  logic                          out_ready;
  logic [ADDR_BITW:0]            out_line_num;
  logic                          out_overflow;
  logic [7:0]                    out_drop_cnt;
  logic                          out_data_valid;
  logic [2*(H_BITW+V_BITW)-1:0]  out_data;

  modport slave (
    input  in_flag, in_valid, in_start_v, in_start_h, in_end_v, in_end_h,
    input  in_rd_en, in_rd_addr, in_release,
    output out_ready, out_line_num, out_overflow, out_drop_cnt,
    output out_data_valid, out_data
  );

  modport master (
    output in_flag, in_valid, in_start_v, in_start_h, in_end_v, in_end_h,
    output in_rd_en, in_rd_addr, in_release,
    input  out_ready, out_line_num, out_overflow, out_drop_cnt,
    input  out_data_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/lsd_output_buffer_db.sv
`default_nettype none
// ============================================================================
//  Module      : lsd_output_buffer_db
//  Description : Ping-pong line-segment store between simple_lsd and the PS.
//                One bank is filled with the current frame's segments while
//                the PS reads the previously committed frame from the other.
//                A frame that ends while the PS still holds the read bank is
//                discarded and counted (saturating at 255).
//  Ports       : clock, n_rst (async, active-low)
//                bus (slave) : segment input, PS read port, PS status
//  Note        : RAM_SIZE >= 2 and a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsd_output_buffer_db #(
  parameter int FRAME_HEIGHT = 525,
  parameter int FRAME_WIDTH  = 800,
  parameter int RAM_SIZE     = 4096
) (
  input wire                     clock,
  input wire                     n_rst,
  lsd_output_buffer_db_if.slave  bus
);

  localparam int c_V_BITW      = $clog2(FRAME_HEIGHT);
  localparam int c_H_BITW      = $clog2(FRAME_WIDTH);
  localparam int c_ADDR_BITW   = $clog2(RAM_SIZE);
  localparam int c_WORD        = 2 * (c_H_BITW + c_V_BITW);
  localparam int c_BANK_WORDS  = 1 << c_ADDR_BITW;
  localparam logic [c_ADDR_BITW:0] c_DEPTH = (c_ADDR_BITW+1)'(RAM_SIZE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_wr_bank;
  logic [c_ADDR_BITW:0]   r_wr_cnt;
  logic [c_ADDR_BITW:0]   w_wr_cnt_nxt;
  logic                   r_ovf;
  logic                   w_ovf_nxt;
  logic                   w_wr_en;
  logic [c_ADDR_BITW-1:0] w_wr_addr;
  logic                   w_commit;
  logic                   w_drop;
  logic                   w_free;
  logic [c_WORD-1:0]      w_wr_word;

  logic                   r_ready;
  logic [c_ADDR_BITW:0]   r_line_num;
  logic                   r_overflow;
  logic [7:0]             r_drop_cnt;
  logic                   r_data_valid;
  logic [c_WORD-1:0]      r_data;

  // Both banks in one array; the bank select is the address MSB.
  logic [c_WORD-1:0]      r_mem [0:2*c_BANK_WORDS-1];

  // The read bank can accept a new frame if nothing is held, or if the PS
  // gives it back on the very edge the frame ends.
  assign w_free    = ~r_ready | bus.in_release;
  assign w_wr_word = {bus.in_start_v, bus.in_start_h, bus.in_end_v, bus.in_end_h};

  // --------------------------------------------------------------------------
  // FSM state register and write-side bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= ST_IDLE;
      r_wr_cnt <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state / control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_ovf_nxt    = r_ovf;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_wr_cnt[c_ADDR_BITW-1:0];
    w_commit     = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_flag) begin
          // Frame start: counters restart, and a segment already valid on
          // this edge lands at address 0.
          w_state_nxt  = ST_FILL;
          w_wr_cnt_nxt = '0;
          w_ovf_nxt    = 1'b0;
          w_wr_addr    = '0;
          if (bus.in_valid) begin
            w_wr_en      = 1'b1;
            w_wr_cnt_nxt = (c_ADDR_BITW+1)'(1);
          end
        end
      end
      ST_FILL: begin
        if (bus.in_flag) begin
          if (bus.in_valid) begin
            if (r_wr_cnt < c_DEPTH) begin
              w_wr_en      = 1'b1;
              w_wr_cnt_nxt = r_wr_cnt + (c_ADDR_BITW+1)'(1);
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end
        end else begin
          w_state_nxt = ST_IDLE;
          if (w_free) begin
            w_commit = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Bank swap and PS-visible status
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_bank  <= 1'b0;
      r_ready    <= 1'b0;
      r_line_num <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      // Commit takes priority over a simultaneous release: the release
      // frees the bank and the new frame immediately occupies it.
      if (w_commit) begin
        r_wr_bank  <= ~r_wr_bank;
        r_line_num <= r_wr_cnt;
        r_overflow <= r_ovf;
        r_ready    <= 1'b1;
      end else if (bus.in_release) begin
        r_ready <= 1'b0;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Segment storage (contents are not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[{r_wr_bank, w_wr_addr}] <= w_wr_word;
    end
  end

  // --------------------------------------------------------------------------
  // Registered PS read from the bank not being written. Addresses beyond the
  // committed count, or reads with no frame held, return zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_data_valid <= 1'b0;
      r_data       <= '0;
    end else if (bus.in_rd_en) begin
      r_data_valid <= 1'b1;
      if (r_ready && ({1'b0, bus.in_rd_addr} < r_line_num)) begin
        r_data <= r_mem[{~r_wr_bank, bus.in_rd_addr}];
      end else begin
        r_data <= '0;
      end
    end else begin
      r_data_valid <= 1'b0;
    end
  end

  assign bus.out_ready      = r_ready;
  assign bus.out_line_num   = r_line_num;
  assign bus.out_overflow   = r_overflow;
  assign bus.out_drop_cnt   = r_drop_cnt;
  assign bus.out_data_valid = r_data_valid;
  assign bus.out_data       = r_data;

endmodule
`default_nettype wire

// File: tb/tb_lsd_output_buffer_db.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsd_output_buffer_db
//  Description : Self-checking bench for lsd_output_buffer_db. Directed frame
//                table with hand-derived status, hand-written reset and
//                saturation sequences, and randomized frames/releases/reads
//                compared against a frame-level queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsd_output_buffer_db;

  localparam int FH = 16;
  localparam int FW = 16;
  localparam int RS = 8;
  localparam int VB = 4;
  localparam int HB = 4;
  localparam int AB = 3;
  localparam int WS = 16;

  logic clock = 1'b0;
  logic n_rst = 1'b0;
  always #5 clock = ~clock;

  lsd_output_buffer_db_if #(.V_BITW(VB), .H_BITW(HB), .ADDR_BITW(AB)) bus ();

  lsd_output_buffer_db #(
    .FRAME_HEIGHT (FH),
    .FRAME_WIDTH  (FW),
    .RAM_SIZE     (RS)
  ) dut (
    .clock (clock),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level reference model: the frame the PS currently sees.
  logic [WS-1:0] m_rd[$];
  bit            m_ready;
  int            m_line;
  bit            m_ovf;
  int            m_drop;

  typedef struct {
    int nseg;
    bit rel_before;
    bit rel_end;
    bit exp_ready;
    int exp_line;
    bit exp_ovf;
    int exp_drop;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WS-1:0] m_read(input int addr);
    if (!m_ready || addr >= m_line) return '0;
    return m_rd[addr];
  endfunction

  task automatic m_reset();
    m_rd.delete();
    m_ready = 0;
    m_line  = 0;
    m_ovf   = 0;
    m_drop  = 0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".ready"},    64'(bus.out_ready),    64'(m_ready));
    check({tag, ".line_num"}, 64'(bus.out_line_num), 64'(m_line));
    check({tag, ".overflow"}, 64'(bus.out_overflow), 64'(m_ovf));
    check({tag, ".drop_cnt"}, 64'(bus.out_drop_cnt), 64'(m_drop));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ready"},      64'(bus.out_ready),      0);
    check({tag, ".line_num"},   64'(bus.out_line_num),   0);
    check({tag, ".overflow"},   64'(bus.out_overflow),   0);
    check({tag, ".drop_cnt"},   64'(bus.out_drop_cnt),   0);
    check({tag, ".data_valid"}, 64'(bus.out_data_valid), 0);
    check({tag, ".data"},       64'(bus.out_data),       0);
  endtask

  task automatic release_pulse();
    bus.in_release = 1'b1;
    tick();
    bus.in_release = 1'b0;
    if (m_ready) m_ready = 0;
  endtask

  // Sends one frame of n segments (patterned or random, optional bubbles),
  // with a random PS read every cycle of the frame, then ends it.
  task automatic send_frame(input int n, input bit rel_end, input bit rnd, input int tagv);
    logic [WS-1:0] segs[$];
    int  sent  = 0;
    bit  first = 1;
    while (first || sent < n) begin
      bit            v;
      int            ra;
      logic [WS-1:0] w;
      logic [WS-1:0] e;
      logic [3:0]    p;
      first = 0;
      v = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
      if (v) begin
        p = 4'((sent + 1 + tagv) & 15);
        w = rnd ? WS'($urandom) : {p, p, p, p};
        bus.in_start_v = w[15:12];
        bus.in_start_h = w[11:8];
        bus.in_end_v   = w[7:4];
        bus.in_end_h   = w[3:0];
        segs.push_back(w);
        sent++;
      end
      bus.in_valid   = v;
      bus.in_flag    = 1'b1;
      ra             = $urandom_range(0, RS - 1);
      e              = m_read(ra);
      bus.in_rd_en   = 1'b1;
      bus.in_rd_addr = AB'(ra);
      tick();
      check("fill_read.valid", 64'(bus.out_data_valid), 1);
      check("fill_read.data",  64'(bus.out_data),       64'(e));
    end
    bus.in_flag    = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_rd_en   = 1'b0;
    bus.in_release = rel_end;
    tick();
    bus.in_release = 1'b0;
    if (!m_ready || rel_end) begin
      m_rd.delete();
      for (int i = 0; i < n && i < RS; i++) m_rd.push_back(segs[i]);
      m_line  = (n < RS) ? n : RS;
      m_ovf   = (n > RS);
      m_ready = 1;
    end else if (m_drop < 255) begin
      m_drop++;
    end
  endtask

  // Back-to-back reads over the whole address range, then an idle cycle.
  task automatic read_all(input string tag);
    logic [WS-1:0] e = '0;
    bus.in_rd_en = 1'b1;
    for (int a = 0; a < RS; a++) begin
      bus.in_rd_addr = AB'(a);
      e = m_read(a);
      tick();
      check({tag, ".rd_valid"}, 64'(bus.out_data_valid), 1);
      check({tag, ".rd_data"},  64'(bus.out_data),       64'(e));
    end
    bus.in_rd_en = 1'b0;
    tick();
    check({tag, ".idle_valid"}, 64'(bus.out_data_valid), 0);
    check({tag, ".hold_data"},  64'(bus.out_data),       64'(e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    tbl = '{
      '{3,  0, 0, 1, 3, 0, 0},   // first frame commits
      '{5,  0, 0, 1, 3, 0, 1},   // not released: dropped
      '{2,  1, 0, 1, 2, 0, 1},   // release then new frame
      '{12, 1, 0, 1, 8, 1, 1},   // overflow: saturate at RAM_SIZE
      '{4,  0, 1, 1, 4, 0, 1},   // release on the frame-end edge
      '{0,  1, 0, 1, 0, 0, 1}    // zero-segment frame commits
    };

    bus.in_flag = 0; bus.in_valid = 0;
    bus.in_start_v = 0; bus.in_start_h = 0; bus.in_end_v = 0; bus.in_end_h = 0;
    bus.in_rd_en = 0; bus.in_rd_addr = 0; bus.in_release = 0;
    m_reset();

    // Reset state
    repeat (3) tick();
    check_zero("reset");
    n_rst = 1'b1;
    tick();

    // Release with nothing held is ignored
    release_pulse();
    check("idle_release.ready",    64'(bus.out_ready),    0);
    check("idle_release.drop_cnt", 64'(bus.out_drop_cnt), 0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      if (tbl[i].rel_before) begin
        release_pulse();
        check({t, ".released"}, 64'(bus.out_ready), 0);
      end
      send_frame(tbl[i].nseg, tbl[i].rel_end, 0, i);
      check({t, ".ready"},    64'(bus.out_ready),    64'(tbl[i].exp_ready));
      check({t, ".line_num"}, 64'(bus.out_line_num), 64'(tbl[i].exp_line));
      check({t, ".overflow"}, 64'(bus.out_overflow), 64'(tbl[i].exp_ovf));
      check({t, ".drop_cnt"}, 64'(bus.out_drop_cnt), 64'(tbl[i].exp_drop));
      read_all(t);
    end

    // Reset in the middle of a frame, then a clean one-segment frame
    bus.in_flag = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid   = 1'b1;
      bus.in_start_v = 4'(k + 9);
      tick();
    end
    n_rst = 1'b0;
    #2;
    check_zero("mid_reset");
    bus.in_flag  = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check_zero("mid_reset_hold");
    n_rst = 1'b1;
    m_reset();
    tick();
    send_frame(1, 0, 0, 7);
    check("post_reset.ready",    64'(bus.out_ready),    1);
    check("post_reset.line_num", 64'(bus.out_line_num), 1);
    check("post_reset.overflow", 64'(bus.out_overflow), 0);
    check("post_reset.drop_cnt", 64'(bus.out_drop_cnt), 0);
    read_all("post_reset");

    // Randomized frames, releases and reads against the model
    for (int r = 0; r < 60; r++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        send_frame($urandom_range(0, RS + 4), 1'($urandom_range(0, 1)), 1, r);
      end else if (op <= 7) begin
        release_pulse();
      end else begin
        read_all("rnd");
      end
      check_status($sformatf("rnd%0d", r));
    end

    // Drop counter saturation
    send_frame(2, 1, 1, 0);
    for (int d = 0; d < 260; d++) send_frame(0, 0, 0, 0);
    check("sat.drop_cnt", 64'(bus.out_drop_cnt), 255);
    check_status("sat");
    read_all("sat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
